// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced mode/up/down buttons drive RUN/SET_HR/SET_MIN mode and hour/minute step pulses.
// Define TIME_SET_AUTO_REPEAT_EN to enable hold-to-repeat stepping.
module time_set_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       hr_en,
  output logic       min_en,
  output logic       up_down,
  output logic       sec_clr
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} mode_t;
  mode_t state, state_nx;
  logic [2:0] s1, s2, deb, deb_d, press;
  logic mode_p, up_p, dn_p, step, rep;
  if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("time_set_ctrl: cycle parameters must be at least 1");
  end
  // bit 0 = up, bit 1 = down, bit 2 = mode
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      deb_d <= '0;
    end else begin
      s1 <= {btn_mode, btn_down, btn_up};
      s2 <= s1;
      deb_d <= deb;
    end
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic lvl;
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) cnt <= '0;
      else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2[i];
      end else cnt <= cnt + 1'b1;
    assign deb[i] = lvl;
  end
  assign press = deb & ~deb_d;
  assign mode_p = press[2];
  assign up_p = press[0] & ~deb[1];
  assign dn_p = press[1] & ~deb[0];
  assign step = state != RUN && !mode_p && (up_p || dn_p);
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_T = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_T = RW'(REPEAT_CYCLES - 1);
  logic armed, rpt, hold_ok;
  logic [RW-1:0] rcnt;
  // repeat only continues while the same single button stays held in the same field
  assign hold_ok = (deb[0] ^ deb[1]) && state != RUN && !mode_p;
  assign rep = armed && hold_ok && rcnt >= (rpt ? REP_T : HOLD_T);
  always_ff @(posedge clk)
    if (rst || !hold_ok) begin
      armed <= 1'b0;
      rpt <= 1'b0;
      rcnt <= '0;
    end else if (step) begin
      armed <= 1'b1;
      rpt <= 1'b0;
      rcnt <= '0;
    end else if (rep) begin
      rpt <= 1'b1;
      rcnt <= '0;
    end else if (armed && rcnt != '1) rcnt <= rcnt + 1'b1;
`else
  assign rep = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    if (mode_p) state_nx = state == RUN ? SET_HR : state == SET_HR ? SET_MIN : RUN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      run_en <= 1'b1;
      hr_en <= 1'b0;
      min_en <= 1'b0;
      sec_clr <= 1'b0;
      up_down <= 1'b0;
    end else begin
      state <= state_nx;
      run_en <= state_nx == RUN;
      hr_en <= (step || rep) && state == SET_HR;
      min_en <= (step || rep) && state == SET_MIN;
      sec_clr <= mode_p && state == SET_MIN;
      if (step || rep) up_down <= step ? dn_p : deb[1];
    end
  assign mode = state;
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel controller for the alarm clock's time-setting path. It takes three raw push-buttons (mode, up, down), synchronises and debounces them, and tracks RUN / SET_HR / SET_MIN mode. It sits directly upstream of the hour and minute up/down modulo counters, driving their enable and direction inputs with single-cycle pulses, including optional hold-to-repeat. It also gates the seconds path while a field is being set.

## Interface

Parameters:
- DEB_CYCLES, default 1_000_000: consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz). Minimum 1.
- HOLD_CYCLES, default 50_000_000: cycles a single up/down button must be held after its press pulse before auto-repeat starts.
- REPEAT_CYCLES, default 20_000_000: auto-repeat pulse period.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- btn_mode, input, 1: raw mode button, asynchronous, active-high.
- btn_up, input, 1: raw increment button, asynchronous, active-high.
- btn_down, input, 1: raw decrement button, asynchronous, active-high.
- mode, output, 2: 2'b00 RUN, 2'b01 SET_HR, 2'b10 SET_MIN (2'b11 never driven).
- run_en, output, 1: high only in RUN; gates the seconds counter enable.
- hr_en, output, 1: one-cycle step pulse to the hour counter.
- min_en, output, 1: one-cycle step pulse to the minute counter.
- up_down, output, 1: direction for hr_en/min_en; 0 = count up, 1 = count down.
- sec_clr, output, 1: one-cycle pulse on the SET_MIN→RUN transition, used to zero seconds.

## Operation

- **Input conditioning.** Each button passes through a 2-FF synchroniser. A per-button debounce counter, $clog2(DEB_CYCLES+1) bits wide, runs as follows:
  - It increments while the synchronised level differs from the debounced level and clears otherwise.
  - When it reaches DEB_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
- **Press event.** A press is a registered rising edge of a debounced level. Releases generate no events.
- **Mode FSM.** A mode press advances RUN→SET_HR→SET_MIN→RUN.
  - Leaving SET_MIN emits sec_clr in the same cycle the state becomes RUN.
  - run_en = (mode == RUN), registered with the state.
- **Step pulses.** In SET_HR or SET_MIN, an up or down press produces one pulse on hr_en or min_en respectively.
  - up_down is set in the same cycle to 0 for up, 1 for down.
  - up_down holds its last value between pulses.
  - In RUN, up/down presses are ignored.
- **Simultaneous events.**
  - A mode press in the same cycle as an up/down press: the mode press wins and no step pulse is emitted.
  - A press of up while down is debounced-high (or the reverse) is ignored.
  - Both up and down rising in the same cycle: ignored.
- **Mode change while held.** The repeat timer clears. No pulse is emitted in the new field until a fresh press.
- **Reset.** mode = RUN, run_en = 1, hr_en = min_en = sec_clr = 0, up_down = 0. Synchroniser flops, debounced levels and all counters clear.
  - A button held through reset debounces high afterwards and is treated as a press.

## Timing

- Raw input rises and stays stable before clock edge 0: the debounced level rises at edge DEB_CYCLES+1, and the press-driven output (step pulse or mode change) is visible after edge DEB_CYCLES+2.
- Step pulses and sec_clr are exactly one cycle wide. hr_en and min_en are never high together.
- Auto-repeat: with exactly one of up/down debounced-high and mode ≠ RUN, a second pulse occurs HOLD_CYCLES cycles after the press pulse, then one every REPEAT_CYCLES cycles until release.
- Release stops repeat immediately; no pulse is emitted in the release cycle or after it.
- Repeat counter width is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1) bits; it saturates and never wraps.

## Configuration

- TIME_SET_AUTO_REPEAT_EN defined: hold-to-repeat behaves as specified under Timing.
- Not defined: the repeat counter and its logic are removed. Each debounced press yields exactly one pulse regardless of hold duration. HOLD_CYCLES and REPEAT_CYCLES are unused.

## Test plan

Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.

- **Reset state:** rst high 3 cycles with all buttons low → mode=00, run_en=1, hr_en=min_en=sec_clr=0, up_down=0.
- **Debounce and mode cycling:** btn_mode toggles every 2 cycles for 20 cycles → mode stays 00. Then three clean presses, each held 10 cycles → mode goes 01, 10, 00; sec_clr pulses once, on the 10→00 step; each change lands at DEB_CYCLES+2 = 6 edges after the raw rise.
- **Single steps:** in SET_HR, btn_up held 8 cycles → exactly one hr_en pulse with up_down=0. In SET_MIN, btn_down held 8 cycles → exactly one min_en pulse with up_down=1.
- **Auto-repeat:** macro defined, SET_MIN, btn_up held 40 cycles → min_en pulses at press cycle P, P+20, P+25, P+30, P+35; none after release. Macro undefined → only the pulse at P.
- **Conflicts:** btn_up and btn_down rising in the same cycle → no pulses. btn_mode and btn_up rising together in SET_HR → mode=10 and no hr_en.
- **Reset mid-operation:** in SET_HR with auto-repeat active, rst asserted for 1 cycle → next cycle mode=00, all pulses low. btn_up still held → no hr_en pulse, because mode is RUN.
